// File: rtl/sigmadelta_decimator_pkg.sv
// sigmadelta_pkg: shared widths, density/sample mapping constants
// and comb-pipeline state encoding for the sigma-delta demodulator.
package sigmadelta_pkg;

   localparam int SD_SAMPLE_W = 16;

   // density 1.0 and 0.0 in signed sample terms
   localparam logic [SD_SAMPLE_W-1:0] SD_FULL_POS = 16'h7FFF;
   localparam logic [SD_SAMPLE_W-1:0] SD_FULL_NEG = 16'h8000;

   // offset binary <-> two's complement: flip the MSB
   localparam logic [SD_SAMPLE_W-1:0] SD_DENSITY_OFS = 16'h8000;

   localparam int LOG2_DECIM_MIN = 6;
   localparam int LOG2_DECIM_MAX = 10;

   // decimations swallowed after reset before outputs are trusted
   localparam logic [1:0] PRIME_DONE = 2'd3;

   typedef enum logic [1:0] {
      CS_IDLE,
      CS_DIFF1,
      CS_DIFF2,
      CS_DIFF3
   } comb_state_e;

   function automatic int cic_acc_w(input int log2_decim);
      return 3 * log2_decim + 1;
   endfunction

endpackage

// File: rtl/sigmadelta_decimator_if.sv
// sigmadelta_decimator_if: bit stream in, decimated samples out.
// master drives the stream and reads samples; slave is the decimator.
interface sigmadelta_decimator_if;
   import sigmadelta_pkg::*;

   logic                   data_in;
   logic [SD_SAMPLE_W-1:0] sample_out;
   logic                   sample_valid;

   modport master (
      output data_in,
      input  sample_out,
      input  sample_valid
   );

   modport slave (
      input  data_in,
      output sample_out,
      output sample_valid
   );

endinterface

// File: rtl/sigmadelta_decimator_integrators.sv
// cic_integrator_chain: three cascaded integrators running at the
// input rate; all sums wrap modulo 2^W, which the combs undo.
module cic_integrator_chain #(
   parameter int W = 19
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         x,
   output logic [W-1:0] i3
);

   logic [W-1:0] i1_q, i1_d;
   logic [W-1:0] i2_q, i2_d;
   logic [W-1:0] i3_q, i3_d;

   // next integrator values, each stage adds the previous one's state
   always_comb begin
      i1_d = i1_q + {{(W-1){1'b0}}, x};
      i2_d = i2_q + i1_q;
      i3_d = i3_q + i2_q;
   end

   // integrator state registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         i1_q <= '0;
         i2_q <= '0;
         i3_q <= '0;
      end else begin
         i1_q <= i1_d;
         i2_q <= i2_d;
         i3_q <= i3_d;
      end
   end

   assign i3 = i3_q;

endmodule

// File: rtl/sigmadelta_decimator.sv
// sigmadelta_decimator: 1-bit density stream to signed 16-bit samples
// through a sinc^3 CIC decimator by 2^LOG2_DECIM.
module sigmadelta_decimator
   import sigmadelta_pkg::*;
#(
   parameter int LOG2_DECIM = 6
) (
   input logic                   clock,
   input logic                   reset_n,
   sigmadelta_decimator_if.slave sd
);

   localparam int W  = cic_acc_w(LOG2_DECIM);
   localparam int LO = W - 1 - SD_SAMPLE_W;

   if (LOG2_DECIM < LOG2_DECIM_MIN ||
       LOG2_DECIM > LOG2_DECIM_MAX) begin : g_bad_decim
      $fatal(1, "sigmadelta_decimator: LOG2_DECIM out of 6..10");
   end

   logic                  sync1_q, sync1_d;
   logic                  sync2_q, sync2_d;
   logic [LOG2_DECIM-1:0] phase_q, phase_d;
   logic                  strobe;
   logic [W-1:0]          i3;

   comb_state_e           state_q, state_d;
   logic [W-1:0]          s0_q, s0_d;
   logic [W-1:0]          s0_dly_q, s0_dly_d;
   logic [W-1:0]          c1_q, c1_d;
   logic [W-1:0]          c1_dly_q, c1_dly_d;
   logic [W-1:0]          c2_q, c2_d;
   logic [W-1:0]          c2_dly_q, c2_dly_d;
   logic [W-1:0]          c3;
   logic [1:0]            prime_q, prime_d;

   logic [SD_SAMPLE_W-1:0] mapped;
   logic [SD_SAMPLE_W-1:0] sample_q, sample_d;
   logic                   valid_q, valid_d;
   logic                   unused_c3_lsbs;

   // two-flop synchronizer and free-running decimation phase
   always_comb begin
      sync1_d = sd.data_in;
      sync2_d = sync1_q;
      phase_d = phase_q + LOG2_DECIM'(1);
   end

   // front-end registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         phase_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         phase_q <= phase_d;
      end
   end

   assign strobe = &phase_q;

   cic_integrator_chain #(
      .W (W)
   ) u_integrators (
      .clock   (clock),
      .reset_n (reset_n),
      .x       (sync2_q),
      .i3      (i3)
   );

   // final comb and count-to-sample mapping; a full-density count
   // of exactly 2^(W-1) would overflow into the sign, so clamp it
   always_comb begin
      c3 = c2_q - c2_dly_q;
      if (c3[W-1]) begin
         mapped = SD_FULL_POS;
      end else begin
         mapped = c3[W-2:LO] ^ SD_DENSITY_OFS;
      end
   end

   assign unused_c3_lsbs = ^c3[LO:0];

   // comb pipeline sequencing, priming and output strobe
   always_comb begin
      state_d  = state_q;
      s0_d     = s0_q;
      s0_dly_d = s0_dly_q;
      c1_d     = c1_q;
      c1_dly_d = c1_dly_q;
      c2_d     = c2_q;
      c2_dly_d = c2_dly_q;
      prime_d  = prime_q;
      sample_d = sample_q;
      valid_d  = 1'b0;
      if (strobe) begin
         s0_d = i3;
      end
      unique case (state_q)
         CS_IDLE: begin
            if (strobe) begin
               state_d = CS_DIFF1;
            end
         end
         CS_DIFF1: begin
            c1_d     = s0_q - s0_dly_q;
            s0_dly_d = s0_q;
            state_d  = CS_DIFF2;
         end
         CS_DIFF2: begin
            c2_d     = c1_q - c1_dly_q;
            c1_dly_d = c1_q;
            state_d  = CS_DIFF3;
         end
         CS_DIFF3: begin
            c2_dly_d = c2_q;
            sample_d = mapped;
            if (prime_q == PRIME_DONE) begin
               valid_d = 1'b1;
            end else begin
               prime_d = prime_q + 2'd1;
            end
            state_d = CS_IDLE;
         end
         default: begin
            state_d = CS_IDLE;
         end
      endcase
   end

   // comb, delay and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= CS_IDLE;
         s0_q     <= '0;
         s0_dly_q <= '0;
         c1_q     <= '0;
         c1_dly_q <= '0;
         c2_q     <= '0;
         c2_dly_q <= '0;
         prime_q  <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         s0_q     <= s0_d;
         s0_dly_q <= s0_dly_d;
         c1_q     <= c1_d;
         c1_dly_q <= c1_dly_d;
         c2_q     <= c2_d;
         c2_dly_q <= c2_dly_d;
         prime_q  <= prime_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
      end
   end

   assign sd.sample_out   = sample_q;
   assign sd.sample_valid = valid_q;

endmodule

// File: tb/tb_sigmadelta_decimator.sv
// tb_sigmadelta_decimator: scoreboard bench for the sinc^3 decimator
// with constant, alternating, loopback, dithered and reset stimulus.
module tb_sigmadelta_decimator;
   import sigmadelta_pkg::*;

   localparam int L           = 6;
   localparam int R           = 1 << L;
   localparam int FIRST_VALID = 4 * R + 3;

   localparam int M_ZERO   = 0;
   localparam int M_ONE    = 1;
   localparam int M_ALT    = 2;
   localparam int M_MOD    = 3;
   localparam int M_DITHER = 4;

   typedef struct {
      logic [15:0] val;
      int          tol;
   } exp_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   sigmadelta_decimator_if sd_if ();

   sigmadelta_decimator #(
      .LOG2_DECIM (L)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .sd      (sd_if)
   );

   always #5 clock = ~clock;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] mod_acc;
   logic [15:0] lfsr;
   logic        alt_bit;

   // next stream bit; modes 3/4 are a first-order 1-bit modulator
   task automatic gen_bit(input int mode, input logic [15:0] s,
                          output logic b);
      logic [16:0] sum;
      logic [15:0] u;
      case (mode)
         M_ZERO: b = 1'b0;
         M_ONE:  b = 1'b1;
         M_ALT: begin
            alt_bit = ~alt_bit;
            b = alt_bit;
         end
         default: begin
            u = s ^ 16'h8000;
            if (mode == M_DITHER) begin
               lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0);
               u = u + {10'd0, lfsr[5:0]} - 16'd32;
            end
            sum = {1'b0, mod_acc} + {1'b0, u};
            mod_acc = sum[15:0];
            b = sum[16];
         end
      endcase
   endtask

   task automatic do_reset(input logic init);
      reset_n = 1'b0;
      sd_if.data_in = init;
      mod_acc = '0;
      alt_bit = 1'b0;
      sb.delete();
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic push_exp(input int n, input logic [15:0] v,
                           input int tol);
      exp_t e;
      e.val = v;
      e.tol = tol;
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset_n = 1'b0;
      sd_if.data_in = 1'b1;
      repeat (4) @(negedge clock);
      n_checks++;
      if (sd_if.sample_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_out got %h want 0000", sd_if.sample_out);
      end
      n_checks++;
      if (sd_if.sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid got %b want 0", sd_if.sample_valid);
      end
   endtask

   task automatic test_const_one();
      exp_t e;
      logic b;
      int   cyc, first, last;
      do_reset(1'b1);
      push_exp(12, SD_FULL_POS, 0);
      cyc = 0;
      first = -1;
      last = -1;
      while (sb.size() != 0 && cyc < FIRST_VALID + 13 * R) begin
         gen_bit(M_ONE, 16'h0, b);
         sd_if.data_in = b;
         @(negedge clock);
         cyc++;
         if (sd_if.sample_valid === 1'b1) begin
            n_checks++;
            if (first < 0) begin
               first = cyc;
               if (first != FIRST_VALID) begin
                  n_fail++;
                  $display("FAIL one_first_valid cycle %0d want %0d",
                           first, FIRST_VALID);
               end
            end else if (cyc - last != R) begin
               n_fail++;
               $display("FAIL one_period got %0d want %0d",
                        cyc - last, R);
            end
            last = cyc;
            e = sb.pop_front();
            n_checks++;
            if (sd_if.sample_out !== e.val) begin
               n_fail++;
               $display("FAIL one_value got %h want %h",
                        sd_if.sample_out, e.val);
            end
         end
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL one_timeout pending %0d want 0", sb.size());
      end
   endtask

   task automatic test_const_zero();
      exp_t e;
      logic b;
      int   cyc;
      do_reset(1'b0);
      push_exp(10, SD_FULL_NEG, 0);
      cyc = 0;
      while (sb.size() != 0 && cyc < FIRST_VALID + 11 * R) begin
         gen_bit(M_ZERO, 16'h0, b);
         sd_if.data_in = b;
         @(negedge clock);
         cyc++;
         if (sd_if.sample_valid === 1'b1) begin
            e = sb.pop_front();
            n_checks++;
            if (sd_if.sample_out !== e.val) begin
               n_fail++;
               $display("FAIL zero_value got %h want %h",
                        sd_if.sample_out, e.val);
            end
         end
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL zero_timeout pending %0d want 0", sb.size());
      end
   endtask

   task automatic test_alternating();
      exp_t e;
      logic b;
      int   cyc;
      do_reset(1'b0);
      push_exp(10, 16'h0000, 0);
      cyc = 0;
      while (sb.size() != 0 && cyc < FIRST_VALID + 11 * R) begin
         gen_bit(M_ALT, 16'h0, b);
         sd_if.data_in = b;
         @(negedge clock);
         cyc++;
         if (sd_if.sample_valid === 1'b1) begin
            e = sb.pop_front();
            n_checks++;
            if (sd_if.sample_out !== e.val) begin
               n_fail++;
               $display("FAIL alt_value got %h want %h",
                        sd_if.sample_out, e.val);
            end
         end
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL alt_timeout pending %0d want 0", sb.size());
      end
   endtask

   task automatic test_loopback();
      logic [15:0] vals [3];
      exp_t        e;
      logic        b;
      int          cyc, d;
      vals[0] = 16'h4000;
      vals[1] = 16'hC000;
      vals[2] = 16'h0000;
      for (int k = 0; k < 3; k++) begin
         do_reset(1'b0);
         push_exp(10, vals[k], 1);
         cyc = 0;
         while (sb.size() != 0 && cyc < FIRST_VALID + 11 * R) begin
            gen_bit(M_MOD, vals[k], b);
            sd_if.data_in = b;
            @(negedge clock);
            cyc++;
            if (sd_if.sample_valid === 1'b1) begin
               e = sb.pop_front();
               d = int'($signed(sd_if.sample_out)) - int'($signed(e.val));
               if (d < 0) d = -d;
               n_checks++;
               if (d > e.tol || $isunknown(sd_if.sample_out)) begin
                  n_fail++;
                  $display("FAIL loop_value got %h want %h tol %0d",
                           sd_if.sample_out, e.val, e.tol);
               end
            end
         end
         n_checks++;
         if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL loop_timeout pending %0d want 0", sb.size());
         end
      end
   endtask

   task automatic test_lfsr_long();
      exp_t e;
      logic b;
      int   cyc, d;
      do_reset(1'b0);
      push_exp(150, 16'hC000, 16'h0100);
      cyc = 0;
      while (sb.size() != 0 && cyc < 10000 + R) begin
         gen_bit(M_DITHER, 16'hC000, b);
         sd_if.data_in = b;
         @(negedge clock);
         cyc++;
         if (sd_if.sample_valid === 1'b1) begin
            e = sb.pop_front();
            d = int'($signed(sd_if.sample_out)) - int'($signed(e.val));
            if (d < 0) d = -d;
            n_checks++;
            if (d > e.tol || $isunknown(sd_if.sample_out)) begin
               n_fail++;
               $display("FAIL lfsr_value got %h want %h tol %0d",
                        sd_if.sample_out, e.val, e.tol);
            end
         end
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL lfsr_timeout pending %0d want 0", sb.size());
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   cyc;
      do_reset(1'b1);
      push_exp(1, SD_FULL_POS, 0);
      cyc = 0;
      while (cyc < 5 * R + 1) begin
         sd_if.data_in = 1'b1;
         @(negedge clock);
         cyc++;
         if (sd_if.sample_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL mid_extra_valid cycle %0d want none", cyc);
            end else begin
               e = sb.pop_front();
               if (sd_if.sample_out !== e.val) begin
                  n_fail++;
                  $display("FAIL mid_pre_value got %h want %h",
                           sd_if.sample_out, e.val);
               end
            end
         end
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL mid_pre_count pending %0d want 0", sb.size());
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (sd_if.sample_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL mid_reset_out got %h want 0000", sd_if.sample_out);
      end
      n_checks++;
      if (sd_if.sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_valid got %b want 0",
                  sd_if.sample_valid);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      cyc = 0;
      while (sd_if.sample_valid !== 1'b1 && cyc < FIRST_VALID + R) begin
         @(negedge clock);
         cyc++;
      end
      n_checks++;
      if (cyc != FIRST_VALID) begin
         n_fail++;
         $display("FAIL mid_first_valid cycle %0d want %0d",
                  cyc, FIRST_VALID);
      end
      n_checks++;
      if (sd_if.sample_out !== SD_FULL_POS) begin
         n_fail++;
         $display("FAIL mid_post_value got %h want %h",
                  sd_if.sample_out, SD_FULL_POS);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (sd_if.sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_drop_valid got %b want 0",
                  sd_if.sample_valid);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      sd_if.data_in = 1'b0;
      lfsr = 16'hACE1;
      alt_bit = 1'b0;
      mod_acc = '0;
      test_reset();
      test_const_one();
      test_const_zero();
      test_alternating();
      test_loopback();
      test_lfsr_long();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
